// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: pops a show-ahead TX FIFO and hands each byte to the UART TX controller.
// Define UART_TX_FEEDER_TIMEOUT_EN to enable the WAIT_BUSY no-ack timeout and err_no_ack.
module uart_tx_feeder #(
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  tx_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_inc,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_data_valid,
    output logic [15:0]           frame_cnt,
    output logic                  err_no_ack
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_e;

    // The gap counter only ever holds GAP_CYCLES-1 down to 0.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_tx_feeder: TIMEOUT_CYCLES must be >= 2");
    end
    if (GAP_CYCLES < 0) begin : g_bad_gap
        $error("uart_tx_feeder: GAP_CYCLES must be >= 0");
    end

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    issue_q, issue_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [GAP_W-1:0]        gap_q, gap_d;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0]         to_q, to_d;
    logic                    err_q, err_d;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        p_data_d = p_data_q;
        issue_d  = 1'b0;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        to_d     = to_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (tx_en && !fifo_empty && !tx_busy) begin
                    p_data_d = fifo_rd_data;
                    issue_d  = 1'b1;
                    state_d  = WAIT_BUSY;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
                    to_d     = '0;
`endif
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
`ifdef UART_TX_FEEDER_TIMEOUT_EN
                else begin
                    to_d = to_q + 1'b1;
                    // The popped byte is abandoned; the next issue reads the new FIFO head.
                    if (to_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
`endif
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d = cnt_q + 16'd1;
                    if (GAP_CYCLES > 0) begin
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous; RST is only looked at on a rising CLK edge.
        if (!RST) begin
            state_q  <= IDLE;
            p_data_q <= '0;
            issue_q  <= 1'b0;
            cnt_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            p_data_q <= p_data_d;
            issue_q  <= issue_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
        end
    end

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign err_no_ack = err_q;
`else
    assign err_no_ack = 1'b0;
`endif

    // Pop and frame request come from one flop, so they can never drift apart.
    assign tx_data_valid = issue_q;
    assign fifo_rd_inc   = issue_q;
    assign tx_p_data     = p_data_q;
    assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: back-to-back instance (a) and GAP_CYCLES=5 instance (b),
// each with a show-ahead FIFO model and a TX model that raises busy in the data_valid cycle.
module tb_uart_tx_feeder;

    localparam int BUSY_LEN = 11;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic tx_en = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- instance a: GAP_CYCLES = 0 ----------------
    logic [7:0]  fifo_rd_data_a, tx_p_data_a;
    logic        fifo_empty_a, fifo_rd_inc_a, tx_busy_a, tx_data_valid_a, err_no_ack_a;
    logic [15:0] frame_cnt_a;

    uart_tx_feeder #(.DATA_WIDTH(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(4)) dut_a (
        .CLK          (CLK),
        .RST          (RST),
        .tx_en        (tx_en),
        .fifo_rd_data (fifo_rd_data_a),
        .fifo_empty   (fifo_empty_a),
        .fifo_rd_inc  (fifo_rd_inc_a),
        .tx_busy      (tx_busy_a),
        .tx_p_data    (tx_p_data_a),
        .tx_data_valid(tx_data_valid_a),
        .frame_cnt    (frame_cnt_a),
        .err_no_ack   (err_no_ack_a)
    );

    logic [7:0] fa_mem [0:15];
    int fa_wr = 0, fa_rd = 0, pops_a = 0;
    assign fifo_empty_a   = (fa_rd == fa_wr);
    assign fifo_rd_data_a = fa_mem[fa_rd[3:0]];
    always @(posedge CLK) if (fifo_rd_inc_a === 1'b1) begin
        fa_rd  <= fa_rd + 1;
        pops_a <= pops_a + 1;
    end

    logic ack_a = 1'b1, force_busy_a = 1'b0;
    int bcnt_a = 0;
    assign tx_busy_a = force_busy_a | (ack_a & (tx_data_valid_a | (bcnt_a != 0)));
    always @(posedge CLK) begin
        if (ack_a && tx_data_valid_a) bcnt_a <= BUSY_LEN - 1;
        else if (bcnt_a != 0)         bcnt_a <= bcnt_a - 1;
    end

    logic [7:0] vdat_a [0:31];
    int gapv_a [0:31];
    int nval_a = 0, fall_a = 0, wide_a = 0, mis_a = 0;
    logic busy_prev_a = 1'b0, val_prev_a = 1'b0;
    always @(posedge CLK) begin
        busy_prev_a <= tx_busy_a;
        val_prev_a  <= tx_data_valid_a;
        if (busy_prev_a && !tx_busy_a) fall_a <= cyc;
        if (tx_data_valid_a !== fifo_rd_inc_a) mis_a <= mis_a + 1;
        if (tx_data_valid_a && val_prev_a) wide_a <= wide_a + 1;
        if (tx_data_valid_a) begin
            vdat_a[nval_a[4:0]] <= tx_p_data_a;
            gapv_a[nval_a[4:0]] <= cyc - fall_a;
            nval_a <= nval_a + 1;
        end
    end

    // ---------------- instance b: GAP_CYCLES = 5 ----------------
    logic [7:0]  fifo_rd_data_b, tx_p_data_b;
    logic        fifo_empty_b, fifo_rd_inc_b, tx_busy_b, tx_data_valid_b, err_no_ack_b;
    logic [15:0] frame_cnt_b;

    uart_tx_feeder #(.DATA_WIDTH(8), .GAP_CYCLES(5), .TIMEOUT_CYCLES(4)) dut_b (
        .CLK          (CLK),
        .RST          (RST),
        .tx_en        (tx_en),
        .fifo_rd_data (fifo_rd_data_b),
        .fifo_empty   (fifo_empty_b),
        .fifo_rd_inc  (fifo_rd_inc_b),
        .tx_busy      (tx_busy_b),
        .tx_p_data    (tx_p_data_b),
        .tx_data_valid(tx_data_valid_b),
        .frame_cnt    (frame_cnt_b),
        .err_no_ack   (err_no_ack_b)
    );

    logic [7:0] fb_mem [0:3];
    int fb_wr = 0, fb_rd = 0, pops_b = 0;
    assign fifo_empty_b   = (fb_rd == fb_wr);
    assign fifo_rd_data_b = fb_mem[fb_rd[1:0]];
    always @(posedge CLK) if (fifo_rd_inc_b === 1'b1) begin
        fb_rd  <= fb_rd + 1;
        pops_b <= pops_b + 1;
    end

    int bcnt_b = 0;
    assign tx_busy_b = tx_data_valid_b | (bcnt_b != 0);
    always @(posedge CLK) begin
        if (tx_data_valid_b)   bcnt_b <= BUSY_LEN - 1;
        else if (bcnt_b != 0)  bcnt_b <= bcnt_b - 1;
    end

    logic [7:0] vdat_b [0:7];
    int gapv_b [0:7];
    int nval_b = 0, fall_b = 0, wide_b = 0, mis_b = 0;
    logic busy_prev_b = 1'b0, val_prev_b = 1'b0;
    always @(posedge CLK) begin
        busy_prev_b <= tx_busy_b;
        val_prev_b  <= tx_data_valid_b;
        if (busy_prev_b && !tx_busy_b) fall_b <= cyc;
        if (tx_data_valid_b !== fifo_rd_inc_b) mis_b <= mis_b + 1;
        if (tx_data_valid_b && val_prev_b) wide_b <= wide_b + 1;
        if (tx_data_valid_b) begin
            vdat_b[nval_b[2:0]] <= tx_p_data_b;
            gapv_b[nval_b[2:0]] <= cyc - fall_b;
            nval_b <= nval_b + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push_a(input logic [7:0] b);
        fa_mem[fa_wr[3:0]] = b;
        fa_wr = fa_wr + 1;
    endtask

    task automatic push_b(input logic [7:0] b);
        fb_mem[fb_wr[1:0]] = b;
        fb_wr = fb_wr + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int exp_cnt, exp_pops, exp_nval;

    initial begin
        // Reset state
        tick(3);
        check("rst_p_data", 32'(tx_p_data_a), 32'h0);
        check("rst_valid",  32'(tx_data_valid_a), 32'h0);
        check("rst_inc",    32'(fifo_rd_inc_a), 32'h0);
        check("rst_cnt",    32'(frame_cnt_a), 32'h0);
        check("rst_err",    32'(err_no_ack_a), 32'h0);
        check("rst_cnt_b",  32'(frame_cnt_b), 32'h0);
        RST = 1'b1;
        tx_en = 1'b1;

        // Single frame, data held through WAIT_DONE
        push_a(8'hA5);
        tick(6);
        check("t1_hold", 32'(tx_p_data_a), 32'hA5);
        tick(14);
        check("t1_nval", nval_a, 1);
        check("t1_data", 32'(vdat_a[0]), 32'hA5);
        check("t1_cnt",  32'(frame_cnt_a), 32'd1);
        check("t1_pops", pops_a, 1);
        check("t1_err",  32'(err_no_ack_a), 32'h0);

        // Three back-to-back frames, valid two edges after busy-low
        push_a(8'h11); push_a(8'h22); push_a(8'h33);
        tick(50);
        check("t2_nval",  nval_a, 4);
        check("t2_d0",    32'(vdat_a[1]), 32'h11);
        check("t2_d1",    32'(vdat_a[2]), 32'h22);
        check("t2_d2",    32'(vdat_a[3]), 32'h33);
        check("t2_gap1",  gapv_a[2], 2);
        check("t2_gap2",  gapv_a[3], 2);
        check("t2_cnt",   32'(frame_cnt_a), 32'd4);
        check("t2_pops",  pops_a, 4);

        // GAP_CYCLES=5: second valid seen 5+2 edges after busy-low
        push_b(8'hC1); push_b(8'hC2);
        tick(50);
        check("t3_nval", nval_b, 2);
        check("t3_d0",   32'(vdat_b[0]), 32'hC1);
        check("t3_d1",   32'(vdat_b[1]), 32'hC2);
        check("t3_gap",  gapv_b[1], 7);
        check("t3_cnt",  32'(frame_cnt_b), 32'd2);
        check("t3_pops", pops_b, 2);

        // No-ack from the TX controller
        ack_a = 1'b0;
        push_a(8'h5A);
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        tick(4);
        check("t4_err_early", 32'(err_no_ack_a), 32'h0);
        tick(1);
        check("t4_err_set", 32'(err_no_ack_a), 32'h1);
        ack_a = 1'b1;
        push_a(8'h6B);
        tick(20);
        exp_cnt = 5;
        check("t4_err_sticky", 32'(err_no_ack_a), 32'h1);
`else
        tick(20);
        check("t4_err_tied", 32'(err_no_ack_a), 32'h0);
        push_a(8'h6B);
        tick(10);
        check("t4_stuck_nval", nval_a, 5);
        check("t4_stuck_pops", pops_a, 5);
        ack_a = 1'b1;
        force_busy_a = 1'b1;
        tick(2);
        force_busy_a = 1'b0;
        tick(20);
        exp_cnt = 6;
        check("t4_err_tied2", 32'(err_no_ack_a), 32'h0);
`endif
        check("t4_cnt",   32'(frame_cnt_a), 32'(exp_cnt));
        check("t4_pops",  pops_a, 6);
        check("t4_nval",  nval_a, 6);
        check("t4_d5a",   32'(vdat_a[4]), 32'h5A);
        check("t4_d6b",   32'(vdat_a[5]), 32'h6B);

        // tx_en gating and mid-frame deassertion
        tx_en = 1'b0;
        push_a(8'h7C);
        tick(10);
        check("t5_no_issue", nval_a, 6);
        check("t5_no_pop",   pops_a, 6);
        tx_en = 1'b1;
        tick(4);
        push_a(8'h8D);
        tx_en = 1'b0;
        tick(20);
        check("t5_nval",    nval_a, 7);
        check("t5_d",       32'(vdat_a[6]), 32'h7C);
        check("t5_cnt",     32'(frame_cnt_a), 32'(exp_cnt + 1));
        check("t5_pops",    pops_a, 7);
        tx_en = 1'b1;
        tick(20);
        check("t5_resume",  32'(vdat_a[7]), 32'h8D);
        check("t5_cnt2",    32'(frame_cnt_a), 32'(exp_cnt + 2));

        // frame_cnt wrap
        force dut_a.cnt_q = 16'hFFFE;
        tick(1);
        release dut_a.cnt_q;
        check("t6_preload", 32'(frame_cnt_a), 32'hFFFE);
        push_a(8'h91); push_a(8'h92);
        tick(14);
        check("t6_ffff", 32'(frame_cnt_a), 32'hFFFF);
        tick(14);
        check("t6_wrap", 32'(frame_cnt_a), 32'h0000);
        check("t6_d",    32'(vdat_a[9]), 32'h92);

        // Reset during WAIT_DONE
        push_a(8'hA0);
        tick(4);
        check("t7_pre", 32'(tx_p_data_a), 32'hA0);
        exp_pops = pops_a;
        exp_nval = nval_a;
        RST = 1'b0;
        tick(1);
        check("t7_p_data", 32'(tx_p_data_a), 32'h0);
        check("t7_valid",  32'(tx_data_valid_a), 32'h0);
        check("t7_inc",    32'(fifo_rd_inc_a), 32'h0);
        check("t7_cnt",    32'(frame_cnt_a), 32'h0);
        check("t7_err",    32'(err_no_ack_a), 32'h0);
        RST = 1'b1;
        tick(20);
        check("t7_no_repop", pops_a, exp_pops);
        check("t7_no_valid", nval_a, exp_nval);
        check("t7_cnt_hold", 32'(frame_cnt_a), 32'h0);

        // Pulse shape over the whole run
        check("valid_eq_inc_a", mis_a, 0);
        check("valid_1cyc_a",   wide_a, 0);
        check("valid_eq_inc_b", mis_b, 0);
        check("valid_1cyc_b",   wide_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
